// File: rtl/ttl_phase_scheduler_pkg.sv
// Shared definitions for the traffic-light phase scheduler: phase encodings,
// service-history constants and timer width.
package ttl_phase_scheduler_pkg;

  localparam int TMR_W = 8;

  typedef enum logic [2:0] {
    ST_MG = 3'd0,
    ST_MY = 3'd1,
    ST_RI = 3'd2,
    ST_SG = 3'd3,
    ST_SY = 3'd4,
    ST_PW = 3'd5,
    ST_PF = 3'd6,
    ST_RO = 3'd7
  } state_e;

  localparam logic LAST_PED  = 1'b0;
  localparam logic LAST_SIDE = 1'b1;

endpackage

// File: rtl/ttl_phase_timer.sv
// Per-phase down-counter: loaded on phase entry, decremented on tick, holds at 0.
// Load takes priority over a coincident tick; expired is combinational from the count.
module ttl_phase_timer
  import ttl_phase_scheduler_pkg::*;
#(
  parameter logic [TMR_W-1:0] RST_VAL = 8'd4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             tick,
  output logic             expired
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/ttl_phase_scheduler.sv
// Intersection sequencer: main street rests green, latched side/pedestrian requests
// are served round-robin; lamps are Moore-decoded from the phase register.
module ttl_phase_scheduler
  import ttl_phase_scheduler_pkg::*;
#(
  parameter int unsigned G_MIN = 4,
  parameter int unsigned Y_T   = 2,
  parameter int unsigned R_T   = 1,
  parameter int unsigned SG_T  = 5,
  parameter int unsigned W_T   = 3,
  parameter int unsigned F_T   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic side_req,
  input  logic ped_req,
  output logic main_r,
  output logic main_y,
  output logic main_g,
  output logic side_r,
  output logic side_y,
  output logic side_g,
  output logic walk,
  output logic dont_walk,
  output logic ped_ack
);

  localparam logic [TMR_W-1:0] G_MIN_C = TMR_W'(G_MIN);
  localparam logic [TMR_W-1:0] Y_T_C   = TMR_W'(Y_T);
  localparam logic [TMR_W-1:0] R_T_C   = TMR_W'(R_T);
  localparam logic [TMR_W-1:0] SG_T_C  = TMR_W'(SG_T);
  localparam logic [TMR_W-1:0] W_T_C   = TMR_W'(W_T);
  localparam logic [TMR_W-1:0] F_T_C   = TMR_W'(F_T);

  function automatic logic [TMR_W-1:0] dur_of(input state_e s);
    case (s)
      ST_MG:        dur_of = G_MIN_C;
      ST_MY, ST_SY: dur_of = Y_T_C;
      ST_SG:        dur_of = SG_T_C;
      ST_PW:        dur_of = W_T_C;
      ST_PF:        dur_of = F_T_C;
      default:      dur_of = R_T_C;
    endcase
  endfunction

  state_e state_q, state_d;
  logic   side_pend_q, side_pend_d;
  logic   ped_pend_q, ped_pend_d;
  logic   last_q, last_d;
  logic   flash_ph_q, flash_ph_d;
  logic   ped_ack_q, ped_ack_d;
  logic   expired;
  logic   enter;

  ttl_phase_timer #(
    .RST_VAL (G_MIN_C)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (enter),
    .load_val (dur_of(state_d)),
    .tick     (tick),
    .expired  (expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MG: if (expired && (side_pend_q || ped_pend_q)) state_d = ST_MY;
      ST_MY: if (expired) state_d = ST_RI;
      ST_RI: begin
        // Pedestrians win only if the side street was served last or is idle.
        if (expired) begin
          state_d = (ped_pend_q && ((last_q == LAST_SIDE) || !side_pend_q)) ? ST_PW : ST_SG;
        end
      end
      ST_SG: if (expired) state_d = ST_SY;
      ST_SY: if (expired) state_d = ST_RO;
      ST_PW: if (expired) state_d = ST_PF;
      ST_PF: if (expired) state_d = ST_RO;
      ST_RO: if (expired) state_d = ST_MG;
      default: state_d = ST_MG;
    endcase
  end

  assign enter = (state_d != state_q);

  always_comb begin
    side_pend_d = (enter && (state_d == ST_SG)) ? 1'b0 : (side_pend_q | side_req);
    ped_pend_d  = (enter && (state_d == ST_PW)) ? 1'b0 : (ped_pend_q | ped_req);
    ped_ack_d   = enter && (state_d == ST_PW);
    last_d      = last_q;
    if (enter && (state_d == ST_SG)) last_d = LAST_SIDE;
    if (enter && (state_d == ST_PW)) last_d = LAST_PED;
    flash_ph_d  = flash_ph_q;
    if (enter && (state_d == ST_PF)) begin
      flash_ph_d = 1'b0;
    end else if ((state_q == ST_PF) && tick) begin
      flash_ph_d = ~flash_ph_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_MG;
      side_pend_q <= 1'b0;
      ped_pend_q  <= 1'b0;
      last_q      <= LAST_PED;
      flash_ph_q  <= 1'b0;
      ped_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      side_pend_q <= side_pend_d;
      ped_pend_q  <= ped_pend_d;
      last_q      <= last_d;
      flash_ph_q  <= flash_ph_d;
      ped_ack_q   <= ped_ack_d;
    end
  end

  assign main_g    = (state_q == ST_MG);
  assign main_y    = (state_q == ST_MY);
  assign main_r    = !(main_g || main_y);
  assign side_g    = (state_q == ST_SG);
  assign side_y    = (state_q == ST_SY);
  assign side_r    = !(side_g || side_y);
  assign walk      = (state_q == ST_PW);
  assign dont_walk = (state_q == ST_PF) ? ~flash_ph_q : (state_q != ST_PW);
  assign ped_ack   = ped_ack_q;

endmodule

// File: tb/tb_ttl_phase_scheduler.sv
// Scoreboard bench: a phase-level reference model predicts the lamp vector each clk,
// a negedge monitor compares the DUT against it and checks the lamp safety rules.
module tb_ttl_phase_scheduler;

  localparam int MG = 0, MY = 1, RI = 2, SG = 3, SY = 4, PW = 5, PF = 6, RO = 7;
  localparam int G_MIN = 4;

  logic clk, reset, tick, side_req, ped_req;
  logic main_r, main_y, main_g, side_r, side_y, side_g, walk, dont_walk, ped_ack;

  ttl_phase_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .side_req  (side_req),
    .ped_req   (ped_req),
    .main_r    (main_r),
    .main_y    (main_y),
    .main_g    (main_g),
    .side_r    (side_r),
    .side_y    (side_y),
    .side_g    (side_g),
    .walk      (walk),
    .dont_walk (dont_walk),
    .ped_ack   (ped_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Phase durations in ticks and fixed successors (RI and MG choose dynamically).
  int dur  [8] = '{G_MIN, 2, 1, 5, 2, 3, 2, 1};
  int succ [8] = '{MY, RI, SG, SY, RO, PF, RO, MG};

  int m_ph, m_left;
  bit m_sp, m_pp, m_last_side, m_flash, m_ack;

  logic [8:0] expq[$];
  int checks, errors, cyc_n;
  bit rand_tick;

  task automatic model_step(input bit rst, input bit tk, input bit sreq, input bit preq);
    int nph;
    if (rst) begin
      m_ph = MG; m_left = G_MIN; m_sp = 0; m_pp = 0;
      m_last_side = 0; m_flash = 0; m_ack = 0;
      return;
    end
    nph = m_ph;
    if (m_left == 0) begin
      if (m_ph == MG)      nph = (m_sp || m_pp) ? MY : MG;
      else if (m_ph == RI) nph = (m_pp && (m_last_side || !m_sp)) ? PW : SG;
      else                 nph = succ[m_ph];
    end
    m_ack = (nph == PW) && (m_ph != PW);
    m_sp  = m_sp | sreq;
    m_pp  = m_pp | preq;
    if (nph != m_ph) begin
      if (nph == SG) begin m_sp = 0; m_last_side = 1; end
      if (nph == PW) begin m_pp = 0; m_last_side = 0; end
      if (nph == PF) m_flash = 0;
      m_left = dur[nph];
    end else begin
      if (tk && m_left > 0) m_left--;
      if (m_ph == PF && tk) m_flash = !m_flash;
    end
    m_ph = nph;
  endtask

  // {main_r,main_y,main_g,side_r,side_y,side_g,walk,dont_walk,ped_ack}
  function automatic logic [8:0] expected_lamps();
    logic dw;
    dw = (m_ph == PW) ? 1'b0 : (m_ph == PF) ? !m_flash : 1'b1;
    return {!(m_ph == MG || m_ph == MY), m_ph == MY, m_ph == MG,
            !(m_ph == SG || m_ph == SY), m_ph == SY, m_ph == SG,
            m_ph == PW, dw, m_ack};
  endfunction

  function automatic bit model_enters_sg();
    return (m_ph == RI) && (m_left == 0) && !(m_pp && (m_last_side || !m_sp));
  endfunction

  task automatic cyc(input bit r, input bit s, input bit p);
    reset    = r;
    side_req = s;
    ped_req  = p;
    tick     = rand_tick ? ($urandom_range(0, 3) == 0) : ((cyc_n % 4) == 3);
    @(posedge clk);
    model_step(reset, tick, side_req, ped_req);
    expq.push_back(expected_lamps());
    cyc_n++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  always @(negedge clk) begin
    logic [8:0] act, exp_v;
    if (expq.size() > 0) begin
      exp_v = expq.pop_front();
      act   = {main_r, main_y, main_g, side_r, side_y, side_g, walk, dont_walk, ped_ack};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL lamps cycle=%0d actual=%b required=%b", cyc_n, act, exp_v);
      end
      checks++;
      if ((32'(main_r) + 32'(main_y) + 32'(main_g) != 1) ||
          (32'(side_r) + 32'(side_y) + 32'(side_g) != 1) ||
          (32'(main_g) + 32'(side_g) + 32'(walk) > 1) || (walk && dont_walk)) begin
        errors++;
        $display("FAIL invariant cycle=%0d actual=%b required=safe lamp set", cyc_n, act);
      end
    end
  end

  initial begin
    checks = 0; errors = 0; cyc_n = 0; rand_tick = 0;
    reset = 1; tick = 0; side_req = 0; ped_req = 0;

    // Reset, then 100 idle ticks
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    idle(400);

    // Single side request, full side round
    idle(3); cyc(0, 1, 0); idle(100);

    // Pedestrian request after main green already expired
    idle(24); cyc(0, 0, 1); idle(80);

    // Contention: side first, then pedestrians without a new press
    cyc(0, 1, 1); idle(200);

    // Both held: alternating service
    for (int i = 0; i < 300; i++) cyc(0, 1, 1);
    idle(150);

    // Pedestrian held across walk entry re-latches
    for (int i = 0; i < 60; i++) cyc(0, 0, 1);
    idle(150);

    // Side pulse only on the SG entry clk is swallowed
    cyc(0, 1, 0);
    begin
      int i;
      for (i = 0; i < 200 && !model_enters_sg(); i++) cyc(0, 0, 0);
      checks++;
      if (!model_enters_sg()) begin
        errors++;
        $display("FAIL sg_entry_wait actual=not reached required=reached within 200 clks");
      end
      cyc(0, 1, 0);
      idle(100);
    end

    // Reset during flashing don't-walk
    cyc(0, 0, 1);
    begin
      int i;
      for (i = 0; i < 300 && m_ph != PF; i++) cyc(0, 0, 0);
      checks++;
      if (m_ph != PF) begin
        errors++;
        $display("FAIL pf_wait actual=phase %0d required=phase %0d", m_ph, PF);
      end
      cyc(0, 0, 0);
      cyc(1, 0, 0);
      idle(60);
    end

    // Random traffic with irregular ticks and occasional reset
    rand_tick = 1;
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
    end

    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
